lo_nco: RTL

Digital local-oscillator synthesizer that generates the square-wave LO drive consumed by the on-chip double-balanced mixer's LO input. A phase accumulator (NCO) is stepped by a frequency tuning word (FTW). The FTW is loaded over a slow 3-wire serial port from dedicated input pins. Outputs are glitch-free registered in-phase and (optionally) quadrature LO bits, routed to the mixer LO pin and to a dedicated output for observation.

---
 rtl/lo_nco_if.sv | 23 ++
 rtl/lo_nco.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lo_nco_if.sv
// Bundle for the lo_nco control, serial-load and LO output signals.
// The master drives control and serial inputs; the slave (the NCO) drives the LO outputs and status.
interface lo_nco_if;
    logic ena;
    logic sync_clr;
    logic ser_clk;
    logic ser_dat;
    logic ser_cs_n;
    logic lo_i;
    logic lo_q;
    logic ftw_valid;
    logic upd_pulse;

    modport master (
        output ena, sync_clr, ser_clk, ser_dat, ser_cs_n,
        input  lo_i, lo_q, ftw_valid, upd_pulse
    );

    modport slave (
        input  ena, sync_clr, ser_clk, ser_dat, ser_cs_n,
        output lo_i, lo_q, ftw_valid, upd_pulse
    );
endinterface

// File: rtl/lo_nco.sv
// Square-wave LO synthesizer: phase accumulator stepped by a serially loaded tuning word.
// Define LO_QUAD_EN to build the quadrature output; otherwise lo_q is tied low.
module lo_nco #(
    parameter int ACC_W = 24
) (
    input logic     clk,
    input logic     rst_n,
    lo_nco_if.slave bus
);
    localparam int CNT_W = $clog2(ACC_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(ACC_W + 1);

    // Stage [0] and [1] synchronize; stage [2] is the previous value for edge detection.
    logic [2:0] sclk_sr;
    logic [2:0] cs_sr;
    logic [1:0] dat_sr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            dat_sr  <= '0;
            cs_sr   <= '1;
        end else begin
            sclk_sr <= {sclk_sr[1:0], bus.ser_clk};
            dat_sr  <= {dat_sr[0], bus.ser_dat};
            cs_sr   <= {cs_sr[1:0], bus.ser_cs_n};
        end
    end

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic frame_active;

    assign sclk_rise    = sclk_sr[1] & ~sclk_sr[2];
    assign cs_fall      = ~cs_sr[1] & cs_sr[2];
    assign cs_rise      = cs_sr[1] & ~cs_sr[2];
    // Still inside the frame on the cycle cs_n rises, so a coincident clock edge shifts first.
    assign frame_active = ~cs_sr[1] | ~cs_sr[2];

    logic [ACC_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             cs_rise_q;

    // NOTE: the shift register is reset too, so no stale bits survive a reset taken mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            cs_rise_q <= 1'b0;
        end else begin
            cs_rise_q <= cs_rise;
            if (cs_fall) begin
                cnt <= '0;
            end else if (sclk_rise && frame_active) begin
                shreg <= {shreg[ACC_W-2:0], dat_sr[1]};
                if (cnt != CNT_OVR) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    logic             commit;
    logic [ACC_W-1:0] ftw;
    logic             ftw_valid_r;
    logic             upd_pulse_r;

    // The count check runs one cycle after the cs_n rise, after any coincident shift has landed.
    assign commit = cs_rise_q && (cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw         <= '0;
            ftw_valid_r <= 1'b0;
            upd_pulse_r <= 1'b0;
        end else begin
            upd_pulse_r <= commit;
            if (commit) begin
                ftw         <= shreg;
                ftw_valid_r <= |shreg;
            end
        end
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] next_acc;

    // NOTE: next_acc gets a default before any branch so the combinational block cannot infer a latch.
    always_comb begin
        next_acc = acc;
        if (bus.sync_clr) begin
            next_acc = '0;
        end else if (bus.ena) begin
            next_acc = acc + ftw;
        end
    end

    logic lo_i_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            lo_i_r <= 1'b0;
        end else begin
            acc    <= next_acc;
            lo_i_r <= next_acc[ACC_W-1];
        end
    end

`ifdef LO_QUAD_EN
    logic lo_q_r;

    // MSB xor next bit is high for the quarter-turn before lo_i rises, a 90 degree lead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q_r <= 1'b0;
        end else begin
            lo_q_r <= next_acc[ACC_W-1] ^ next_acc[ACC_W-2];
        end
    end

    assign bus.lo_q = lo_q_r;
`else
    assign bus.lo_q = 1'b0;
`endif

    assign bus.lo_i      = lo_i_r;
    assign bus.ftw_valid = ftw_valid_r;
    assign bus.upd_pulse = upd_pulse_r;
endmodule
